// File: rtl/factorial_bcd_engine_pkg.sv
// rtl/factorial_bcd_engine_pkg.sv - state encodings, digit sizing and BCD constants for factorial_bcd_engine
package factorial_pkg;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_INIT = 3'd1;
    localparam logic [2:0] S_MULT = 3'd2;
    localparam logic [2:0] S_CONV = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE = S_IDLE,
        ST_INIT = S_INIT,
        ST_MULT = S_MULT,
        ST_CONV = S_CONV,
        ST_DONE = S_DONE
    } state_t;

    localparam logic [3:0] BCD_THRESH = 4'd5;
    localparam logic [3:0] BCD_ADD3   = 4'd3;

    // ceil(width * log10(2)) in fixed point, enough decimal digits for 2^width-1
    function automatic int min_digits(input int width);
        return (width * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_seq_conv.sv
// rtl/bcd_seq_conv.sv - sequential double-dabble binary to packed BCD converter, WIDTH shift cycles per load
module bcd_seq_conv
    import factorial_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic [WIDTH-1:0]      i_bin,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_bcd
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]    r_bin;
    logic [4*DIGITS-1:0] r_bcd;
    logic [CW-1:0]       r_cnt;
    logic                r_busy;
    logic [4*DIGITS-1:0] w_adj;

    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= BCD_THRESH)
                w_adj[4*d +: 4] = r_bcd[4*d +: 4] + BCD_ADD3;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bin  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_load) begin
            r_bin  <= i_bin;
            r_bcd  <= '0;
            r_cnt  <= CW'(WIDTH);
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_bcd <= {w_adj[4*DIGITS-2:0], r_bin[WIDTH-1]};
            r_bin <= {r_bin[WIDTH-2:0], 1'b0};
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1))
                r_busy <= 1'b0;
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_busy && (r_cnt == CW'(1));
    assign o_bcd  = r_bcd;

endmodule

// File: rtl/factorial_bcd_engine.sv
// rtl/factorial_bcd_engine.sv - iterative saturating n! unit with optional BCD readout
// FACTORIAL_BCD_CONV_EN: when defined, adds the CONV state and drives o_bcd_out from bcd_seq_conv.
module factorial_bcd_engine
    import factorial_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int N_WIDTH = 8,
    parameter int DIGITS  = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_go,
    input  logic [N_WIDTH-1:0]    i_n,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_overflow,
    output logic [WIDTH-1:0]      o_result,
    output logic [4*DIGITS-1:0]   o_bcd_out,
    output logic [2:0]            o_curr_state
);

    if (DIGITS < min_digits(WIDTH)) begin : g_digits_chk
        $error("factorial_bcd_engine: DIGITS too small for WIDTH");
    end

    state_t                     r_state, w_state_next;
    logic [N_WIDTH-1:0]         r_cnt, w_cnt_next;
    logic [WIDTH-1:0]           r_acc, w_acc_next;
    logic                       r_ovf, w_ovf_next;
    logic [WIDTH-1:0]           r_result;
    logic                       r_overflow;
    logic                       r_done;
    logic                       w_mult_exit;
    logic                       w_conv_load;
    logic [WIDTH+N_WIDTH-1:0]   w_prod;

    assign w_prod = {{N_WIDTH{1'b0}}, r_acc} * {{WIDTH{1'b0}}, r_cnt};

`ifdef FACTORIAL_BCD_CONV_EN
    logic                       w_conv_busy;
    logic                       w_conv_done;
    logic [4*DIGITS-1:0]        w_bcd;
    logic [4*DIGITS-1:0]        r_bcd_out;

    bcd_seq_conv #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_conv (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (w_conv_load),
        .i_bin   (w_acc_next),
        .o_busy  (w_conv_busy),
        .o_done  (w_conv_done),
        .o_bcd   (w_bcd)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_bcd_out <= '0;
        else if (r_state == ST_DONE)
            r_bcd_out <= w_bcd;
    end

    assign o_bcd_out = r_bcd_out;
`else
    assign o_bcd_out = '0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_acc_next   = r_acc;
        w_ovf_next   = r_ovf;
        w_mult_exit  = 1'b0;
        w_conv_load  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_go) begin
                    w_cnt_next   = i_n;
                    w_state_next = ST_INIT;
                end
            end
            ST_INIT: begin
                w_acc_next   = WIDTH'(1);
                w_ovf_next   = 1'b0;
                w_state_next = ST_MULT;
            end
            ST_MULT: begin
                if (r_cnt <= N_WIDTH'(1)) begin
                    w_mult_exit = 1'b1;
                end else if (|w_prod[WIDTH+N_WIDTH-1:WIDTH]) begin
                    // saturate and stop multiplying once the product leaves WIDTH bits
                    w_acc_next  = '1;
                    w_ovf_next  = 1'b1;
                    w_mult_exit = 1'b1;
                end else begin
                    w_acc_next = w_prod[WIDTH-1:0];
                    w_cnt_next = r_cnt - N_WIDTH'(1);
                end
                if (w_mult_exit) begin
`ifdef FACTORIAL_BCD_CONV_EN
                    w_conv_load  = 1'b1;
                    w_state_next = ST_CONV;
`else
                    w_state_next = ST_DONE;
`endif
                end
            end
`ifdef FACTORIAL_BCD_CONV_EN
            ST_CONV: begin
                if (w_conv_done || !w_conv_busy)
                    w_state_next = ST_DONE;
            end
`endif
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_acc   <= w_acc_next;
            r_ovf   <= w_ovf_next;
            r_done  <= (r_state == ST_DONE);
            if (r_state == ST_DONE) begin
                r_result   <= r_acc;
                r_overflow <= r_ovf;
            end
        end
    end

    assign o_busy       = (r_state != ST_IDLE);
    assign o_done       = r_done;
    assign o_overflow   = r_overflow;
    assign o_result     = r_result;
    assign o_curr_state = r_state;

endmodule

// File: tb/tb_factorial_bcd_engine.sv
// tb/tb_factorial_bcd_engine.sv - directed self-checking bench for factorial_bcd_engine
module tb_factorial_bcd_engine;

`ifdef FACTORIAL_BCD_CONV_EN
    localparam int  CONV_CYC = 16;
    localparam bit  HAS_BCD  = 1'b1;
`else
    localparam int  CONV_CYC = 0;
    localparam bit  HAS_BCD  = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_go = 1'b0;
    logic [7:0]  i_n = '0;
    logic        o_busy;
    logic        o_done;
    logic        o_overflow;
    logic [15:0] o_result;
    logic [19:0] o_bcd_out;
    logic [2:0]  o_curr_state;

    int n_checks = 0;
    int n_errors = 0;

    always #5 i_clk = ~i_clk;

    factorial_bcd_engine dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_go         (i_go),
        .i_n          (i_n),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_overflow   (o_overflow),
        .o_result     (o_result),
        .o_bcd_out    (o_bcd_out),
        .o_curr_state (o_curr_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_check(input string tag, input int nv, input int exp_lat,
                             input logic [31:0] exp_res, input logic [31:0] exp_bcd,
                             input logic exp_ovf);
        int lat;
        @(negedge i_clk);
        i_n  = 8'(nv);
        i_go = 1'b1;
        @(posedge i_clk);
        #1;
        i_go = 1'b0;
        check({tag, "_init_state"}, 32'(o_curr_state), 32'd1);
        check({tag, "_busy"}, 32'(o_busy), 32'd1);
        lat = 0;
        while (o_done !== 1'b1 && lat < 200) begin
            @(posedge i_clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, 32'(o_result), exp_res);
        check({tag, "_bcd"}, 32'(o_bcd_out), HAS_BCD ? exp_bcd : 32'd0);
        check({tag, "_ovf"}, 32'(o_overflow), 32'(exp_ovf));
        @(posedge i_clk);
        #1;
        check({tag, "_done_pulse"}, 32'(o_done), 32'd0);
        check({tag, "_idle"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        int cyc;
        int k;
        int t_done [2];
        int n_done;
        logic [15:0] res_seen;

        repeat (3) @(posedge i_clk);
        #1;
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_result", 32'(o_result), 32'd0);
        check("rst_bcd", 32'(o_bcd_out), 32'd0);
        check("rst_state", 32'(o_curr_state), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        run_check("n5", 5, 7 + CONV_CYC, 32'd120, 32'h00120, 1'b0);
        run_check("n0", 0, 3 + CONV_CYC, 32'd1, 32'h00001, 1'b0);
        run_check("n1", 1, 3 + CONV_CYC, 32'd1, 32'h00001, 1'b0);
        run_check("n8", 8, 10 + CONV_CYC, 32'd40320, 32'h40320, 1'b0);
        run_check("n9", 9, 9 + CONV_CYC, 32'hFFFF, 32'h65535, 1'b1);

        repeat (3) @(posedge i_clk);
        #1;
        check("hold_result", 32'(o_result), 32'hFFFF);
        check("hold_ovf", 32'(o_overflow), 32'd1);

        // go and n changes during a run must be ignored
        @(negedge i_clk);
        i_n  = 8'd6;
        i_go = 1'b1;
        @(negedge i_clk);
        i_go = 1'b0;
        repeat (4) @(negedge i_clk);
        i_n  = 8'd3;
        i_go = 1'b1;
        @(negedge i_clk);
        i_go = 1'b0;
        n_done   = 0;
        res_seen = '0;
        for (int c = 0; c < 60; c++) begin
            @(posedge i_clk);
            #1;
            if (o_done === 1'b1) begin
                n_done++;
                res_seen = o_result;
            end
        end
        check("midgo_pulses", 32'(n_done), 32'd1);
        check("midgo_result", 32'(res_seen), 32'd720);
        check("midgo_ovf", 32'(o_overflow), 32'd0);

        // go held high: back-to-back runs
        @(negedge i_clk);
        i_n  = 8'd5;
        i_go = 1'b1;
        cyc = 0;
        k   = 0;
        while (k < 2 && cyc < 200) begin
            @(posedge i_clk);
            #1;
            cyc++;
            if (o_done === 1'b1) begin
                t_done[k] = cyc;
                k++;
            end
        end
        @(negedge i_clk);
        i_go = 1'b0;
        check("b2b_count", 32'(k), 32'd2);
        if (k == 2)
            check("b2b_spacing", 32'(t_done[1] - t_done[0]), 32'(8 + CONV_CYC));
        repeat (3) @(posedge i_clk);
        #1;
        check("b2b_idle", 32'(o_busy), 32'd0);
        check("b2b_result", 32'(o_result), 32'd120);

        // asynchronous reset during MULT
        @(negedge i_clk);
        i_n  = 8'd7;
        i_go = 1'b1;
        @(negedge i_clk);
        i_go = 1'b0;
        repeat (2) @(negedge i_clk);
        check("pre_rst_state", 32'(o_curr_state), 32'd2);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("arst_state", 32'(o_curr_state), 32'd0);
        check("arst_busy", 32'(o_busy), 32'd0);
        check("arst_result", 32'(o_result), 32'd0);
        check("arst_bcd", 32'(o_bcd_out), 32'd0);
        check("arst_ovf", 32'(o_overflow), 32'd0);
        check("arst_done", 32'(o_done), 32'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;

        run_check("n4", 4, 6 + CONV_CYC, 32'd24, 32'h00024, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
